// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter, LSB first.
//
// Ports
//   clk   : clock; all state changes on the rising edge
//   rst   : synchronous, active-high reset
//   data  : byte to send; captured only when a start is accepted in IDLE
//   start : transmit request, level-sampled in IDLE; ignored at all other times
//   Tx    : serial line, idle high, driven straight from a flop
//   busy  : high from the accepted start through the cleanup cycle
//   done  : one-cycle pulse in the cleanup cycle that ends each frame
//
// Parameter
//   CLOCK_PER_BIT : clk cycles per serial bit, 2..1023 (default 868 = 100 MHz / 115200)
module uart_transmitter #(
  parameter int CLOCK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       Tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  localparam logic [9:0] LP_LAST = 10'(CLOCK_PER_BIT - 1);

  state_t     r_state, w_state;
  logic [9:0] r_cnt,   w_cnt;
  logic [2:0] r_idx,   w_idx;
  logic [7:0] r_shift, w_shift;
  logic       r_tx,    w_tx;
  logic       r_busy,  w_busy;
  logic       r_done,  w_done;
  logic       w_bit_end;

  assign w_bit_end = (r_cnt == LP_LAST);

  // Next-state and next-output logic. Every output is computed here one
  // cycle ahead and then registered, so Tx/busy/done come straight off flops.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_tx    = r_tx;
    w_busy  = r_busy;
    w_done  = r_done;
    case (r_state)
      S_IDLE: begin
        w_tx   = 1'b1;
        w_busy = 1'b0;
        w_done = 1'b0;
        if (start) begin
          w_shift = data;
          w_tx    = 1'b0;
          w_busy  = 1'b1;
          w_cnt   = '0;
          w_idx   = '0;
          w_state = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt   = '0;
          w_tx    = r_shift[0];
          w_state = S_DATA;
        end else begin
          w_cnt = r_cnt + 10'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt = '0;
          if (r_idx == 3'd7) begin
            w_tx    = 1'b1;
            w_state = S_STOP;
          end else begin
            // Present the next bit as the index advances.
            w_idx = r_idx + 3'd1;
            w_tx  = r_shift[r_idx + 3'd1];
          end
        end else begin
          w_cnt = r_cnt + 10'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt   = '0;
          w_done  = 1'b1;
          w_busy  = 1'b1;
          w_state = S_CLEANUP;
        end else begin
          w_cnt = r_cnt + 10'd1;
        end
      end
      S_CLEANUP: begin
        w_tx    = 1'b1;
        w_done  = 1'b0;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
      default: begin
        // Illegal encoding: recover to a quiet idle line.
        w_state = S_IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_cnt   = '0;
        w_idx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign Tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a CLOCK_PER_BIT=4 instance for frame
// shape, abort and back-to-back cases, plus a default-rate instance whose line
// is decoded by a simple mid-bit sampling receiver.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       start = 1'b0;
  logic       Tx, busy, done;

  logic [7:0] data2 = 8'h00;
  logic       start2 = 1'b0;
  logic       tx2, busy2, done2;

  int n_chk = 0;
  int n_err = 0;

  logic tx_log   [0:199];
  logic busy_log [0:199];
  logic done_log [0:199];

  always #5 clk = ~clk;

  uart_transmitter #(.CLOCK_PER_BIT(4)) u_dut (
    .clk(clk), .rst(rst), .data(data), .start(start),
    .Tx(Tx), .busy(busy), .done(done)
  );

  uart_transmitter u_dut868 (
    .clk(clk), .rst(rst), .data(data2), .start(start2),
    .Tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sel: 0 = Tx, 1 = busy, 2 = done; counts ones in log[lo..hi]
  function automatic int ones(input int sel, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      if (sel == 0 && tx_log[i])   c++;
      if (sel == 1 && busy_log[i]) c++;
      if (sel == 2 && done_log[i]) c++;
    end
    return c;
  endfunction

  // Entry n of the logs is the output after the n-th edge following the
  // accepting edge (entry 0 = right after start was taken).
  task automatic capture(input logic [7:0] d, input int n, input int hold,
                         input int inj, input logic [7:0] inj_d, input int rst_at);
    @(negedge clk);
    data  = d;
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i]   = Tx;
      busy_log[i] = busy;
      done_log[i] = done;
      start = (i + 1 < hold) || (i == inj);
      if (i == inj) data = inj_d;
      rst = (i == rst_at);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  // frame bit b (0 = start, 1..8 = data LSB first, 9 = stop) must hold 4 cycles
  task automatic check_frame(input string tag, input logic [9:0] bits, input int base);
    logic [9:0] b_v;
    b_v = bits;
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < 4; k++)
        chk($sformatf("%s_bit%0d_c%0d", tag, b, k), 32'(tx_log[base + 4*b + k]), 32'(b_v[b]));
  endtask

  initial begin
    logic [9:0] rx;
    int done_at, done_cnt;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx",    32'(Tx),    32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_tx2",   32'(tx2),   32'd1);
    chk("rst_busy2", 32'(busy2), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_tx",   32'(Tx),   32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // A5, single-cycle start
    capture(8'hA5, 50, 1, -1, 8'h00, -1);
    check_frame("a5", 10'h34A, 0);
    chk("a5_done39",  32'(done_log[39]), 32'd0);
    chk("a5_done40",  32'(done_log[40]), 32'd1);
    chk("a5_done41",  32'(done_log[41]), 32'd0);
    chk("a5_busy40",  32'(busy_log[40]), 32'd1);
    chk("a5_busy41",  32'(busy_log[41]), 32'd0);
    chk("a5_busycnt", 32'(ones(1, 0, 49)), 32'd41);
    chk("a5_donecnt", 32'(ones(2, 0, 49)), 32'd1);

    // all-zero and all-one bytes
    capture(8'h00, 46, 1, -1, 8'h00, -1);
    check_frame("x00", 10'h200, 0);
    chk("x00_lowcnt", 32'(40 - ones(0, 0, 39)), 32'd36);
    capture(8'hFF, 46, 1, -1, 8'h00, -1);
    check_frame("xff", 10'h3FE, 0);
    chk("xff_lowcnt", 32'(40 - ones(0, 0, 39)), 32'd4);

    // start + new data during data bit 3 must be ignored, not queued
    capture(8'hA5, 100, 1, 17, 8'h3C, -1);
    check_frame("inj", 10'h34A, 0);
    chk("inj_busycnt", 32'(ones(1, 0, 99)), 32'd41);
    chk("inj_donecnt", 32'(ones(2, 0, 99)), 32'd1);
    chk("inj_idlehi",  32'(ones(0, 42, 99)), 32'd58);

    // start held high: three back-to-back 55 frames
    capture(8'h55, 140, 100, -1, 8'h00, -1);
    check_frame("b2b0", 10'h2AA, 0);
    check_frame("b2b1", 10'h2AA, 42);
    check_frame("b2b2", 10'h2AA, 84);
    chk("b2b_done40",  32'(done_log[40]),  32'd1);
    chk("b2b_done82",  32'(done_log[82]),  32'd1);
    chk("b2b_done124", 32'(done_log[124]), 32'd1);
    chk("b2b_donecnt", 32'(ones(2, 0, 139)), 32'd3);
    chk("b2b_gaphi",   32'(ones(0, 35, 42)), 32'd6);
    chk("b2b_tx35",    32'(tx_log[35]), 32'd0);
    chk("b2b_tx42",    32'(tx_log[42]), 32'd0);
    chk("b2b_idle",    32'(ones(1, 126, 139)), 32'd0);

    // reset during data bit 5 aborts the frame
    capture(8'h00, 60, 1, -1, 8'h00, 25);
    chk("ab_tx25",   32'(tx_log[25]),   32'd0);
    chk("ab_busy25", 32'(busy_log[25]), 32'd1);
    chk("ab_tx26",   32'(tx_log[26]),   32'd1);
    chk("ab_busy26", 32'(busy_log[26]), 32'd0);
    chk("ab_done26", 32'(done_log[26]), 32'd0);
    chk("ab_donecnt", 32'(ones(2, 0, 59)), 32'd0);
    chk("ab_hi",      32'(ones(0, 26, 59)), 32'd34);
    capture(8'h81, 46, 1, -1, 8'h00, -1);
    check_frame("x81", 10'h302, 0);
    chk("x81_done40", 32'(done_log[40]), 32'd1);

    // reset wins over start on the same edge, and the start is not remembered
    @(negedge clk);
    rst = 1'b1; start = 1'b1; data = 8'hFF;
    @(negedge clk);
    chk("prio_tx",   32'(Tx),   32'd1);
    chk("prio_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("prio_busy_later", 32'(busy), 32'd0);

    // default rate: decode the line by sampling each bit at its centre
    @(negedge clk);
    data2 = 8'h41; start2 = 1'b1;
    rx = '0; done_at = -1; done_cnt = 0;
    for (int i = 0; i < 8690; i++) begin
      @(negedge clk);
      if (i == 0) start2 = 1'b0;
      if (i == 2) data2 = 8'hBE;
      if (i < 8680 && (i % 868) == 434) rx[i / 868] = tx2;
      if (i == 867) chk("b868_start_end", 32'(tx2), 32'd0);
      if (i == 868) chk("b868_bit0_beg",  32'(tx2), 32'd1);
      if (done2) begin
        done_cnt++;
        done_at = i;
      end
    end
    chk("lb_startbit", 32'(rx[0]),   32'd0);
    chk("lb_byte",     32'(rx[8:1]), 32'h41);
    chk("lb_stopbit",  32'(rx[9]),   32'd1);
    chk("lb_done_at",  32'(done_at), 32'd8680);
    chk("lb_donecnt",  32'(done_cnt), 32'd1);
    chk("lb_idle",     32'(busy2),   32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLOCK_PER_BIT, default 868, giving clk cycles per serial bit (100 MHz / 115200 baud); the legal range is 2..1023.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port data, input, 8 bits: the byte to transmit, sampled only when a start is accepted.
REQ-005 The block SHALL have port start, input, 1 bit: transmit request, level-sampled in IDLE.
REQ-006 The block SHALL have port Tx, output, 1 bit: the serial line, idle high.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of each frame.

Function
REQ-009 The block SHALL implement states IDLE, TX_START_BIT, TX_DATA_BITS, TX_STOP_BIT and TX_CLEANUP, all registered; unused encodings SHALL go to IDLE on the next edge.
REQ-010 In IDLE, on an edge with start=1, the block SHALL latch data into an internal shift register, set Tx=0 and busy=1, clear the bit counter and the bit index, and enter TX_START_BIT.
REQ-011 In IDLE with start=0, the block SHALL hold Tx=1, busy=0 and done=0.
REQ-012 In each bit state, Tx SHALL hold its value for exactly CLOCK_PER_BIT cycles, counted by a 10-bit counter running 0..CLOCK_PER_BIT-1 and cleared at each bit boundary.
REQ-013 At the end of TX_START_BIT, the block SHALL drive Tx=data[0] and enter TX_DATA_BITS.
REQ-014 In TX_DATA_BITS, data bits SHALL be sent LSB first, bits 0..7, using a 3-bit index.
REQ-015 After bit 7 completes, the block SHALL set Tx=1 and enter TX_STOP_BIT.
REQ-016 At the end of TX_STOP_BIT, the block SHALL enter TX_CLEANUP with done=1 and busy=1.
REQ-017 In TX_CLEANUP, the block SHALL spend one cycle, then enter IDLE with done=0 and busy=0.
REQ-018 The low time of Tx from the start bit through the last data bit SHALL span exactly 9*CLOCK_PER_BIT cycles, and the full frame (start + 8 data + stop) SHALL span 10*CLOCK_PER_BIT cycles.
REQ-019 Tx SHALL be driven directly from a register, never from combinational logic, so that it has no glitches.
REQ-020 start asserted in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-021 Changes on data while busy=1 SHALL NOT affect the frame in progress.
REQ-022 With start held high continuously, frames SHALL repeat back-to-back with exactly 2 extra high cycles (TX_CLEANUP + IDLE) after each stop bit.
REQ-023 done SHALL never be high for more than one consecutive cycle, and SHALL be high only while busy=1.

Reset
REQ-024 When rst=1 on a rising edge, the block SHALL set state=IDLE, Tx=1, busy=0, done=0, counter=0, index=0 and shift register=0, regardless of the current state.
REQ-025 rst SHALL take priority over start on the same edge.
REQ-026 A reset mid-frame SHALL abort the frame with Tx high from the next cycle, and SHALL produce no done pulse.
REQ-027 The first start accepted after rst deasserts SHALL produce a complete, correct frame.

Verification (CLOCK_PER_BIT=4 unless stated)
REQ-028 The bench SHALL cover: data=8'hA5, start pulsed 1 cycle -> Tx sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles; done high exactly 1 cycle after the stop bit; busy high 41 cycles.
REQ-029 The bench SHALL cover: data=8'h00 then 8'hFF -> Tx low for 36 cycles, then high 4 (stop bit); for 8'hFF, Tx low 4 cycles then high 36.
REQ-030 The bench SHALL cover: start re-pulsed with data=8'h3C during bit 3 of an 8'hA5 frame -> the 8'hA5 frame is unchanged, and no second frame follows.
REQ-031 The bench SHALL cover: start held high with data=8'h55 for 3 frames -> 3 done pulses spaced 42 cycles apart, with Tx high for 6 cycles between frames.
REQ-032 The bench SHALL cover: rst=1 for 1 cycle during bit 5 -> Tx=1, busy=0, done=0 on the next cycle; a subsequent start with 8'h81 yields a correct frame.
REQ-033 The bench SHALL cover: default CLOCK_PER_BIT=868, data=8'h41 -> each bit 868 cycles; loopback into the existing 115200-baud receiver yields data=8'h41 with its done asserted.
